// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Brief    : Behavioural-equivalent 16-bit SRAM chip with programmable read
//            latency and byte-lane-masked writes on a shared DQ bus.
// Revision : 1.0
// ============================================================================
module sram_responder #(
    parameter int MEM_DEPTH_LOG2 = 16,
    parameter int READ_LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [17:0] SRAM_ADDR,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic        rdValid,
    output logic [15:0] readCount,
    output logic [15:0] writeCount
);

    localparam int         c_DEPTH      = 1 << MEM_DEPTH_LOG2;
    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT       = 2'd1;
    localparam logic [1:0] c_DRIVE      = 2'd2;
    localparam logic [2:0] c_LAT_RELOAD = (READ_LAT >= 2) ? 3'(READ_LAT - 2) : 3'd0;

    logic [15:0]               r_mem [c_DEPTH];
    logic [1:0]                r_state;
    logic [2:0]                r_cnt;
    logic [MEM_DEPTH_LOG2-1:0] r_rdAddr;
    logic [15:0]               r_outReg;

    logic [MEM_DEPTH_LOG2-1:0] w_addrIdx;
    logic                      w_write;
    logic                      w_read;
    logic                      w_drvEn;

    assign w_addrIdx = SRAM_ADDR[MEM_DEPTH_LOG2-1:0];
    assign w_write   = !SRAM_CE_N && !SRAM_WE_N;
    assign w_read    = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;

    // Upper address bits alias onto the implemented words.
    if (MEM_DEPTH_LOG2 < 18) begin : g_unused_addr
        logic w_unusedHi;
        assign w_unusedHi = ^SRAM_ADDR[17:MEM_DEPTH_LOG2];
    end

    // Array has no reset: contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (w_write && !rst) begin
            if (!SRAM_UB_N) r_mem[w_addrIdx][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) r_mem[w_addrIdx][7:0]  <= SRAM_DQ[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= 3'd0;
            r_rdAddr   <= '0;
            r_outReg   <= 16'd0;
            rdValid    <= 1'b0;
            readCount  <= 16'd0;
            writeCount <= 16'd0;
        end else if (w_write) begin
            // A write always wins over an in-flight read.
            writeCount <= writeCount + 16'd1;
            r_state    <= c_IDLE;
            rdValid    <= 1'b0;
        end else if (!w_read) begin
            r_state <= c_IDLE;
            rdValid <= 1'b0;
        end else if (r_state == c_IDLE || w_addrIdx != r_rdAddr) begin
            r_rdAddr <= w_addrIdx;
            if (READ_LAT == 1) begin
                r_state   <= c_DRIVE;
                r_outReg  <= r_mem[w_addrIdx];
                rdValid   <= 1'b1;
                readCount <= readCount + 16'd1;
            end else begin
                r_state <= c_WAIT;
                r_cnt   <= c_LAT_RELOAD;
                rdValid <= 1'b0;
            end
        end else if (r_state == c_WAIT) begin
            if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end else begin
                r_state   <= c_DRIVE;
                r_outReg  <= r_mem[r_rdAddr];
                rdValid   <= 1'b1;
                readCount <= readCount + 16'd1;
            end
        end
    end

    // Lane enables are live so the controller can mask bytes mid-drive.
    assign w_drvEn       = (r_state == c_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign SRAM_DQ[15:8] = (w_drvEn && !SRAM_UB_N) ? r_outReg[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (w_drvEn && !SRAM_LB_N) ? r_outReg[7:0]  : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Brief    : Self-checking bench; four responders with different latency and
//            depth share one bus stimulus; undriven DQ bits read as 1.
// Revision : 1.0
// ============================================================================
module tb_sram_responder;

    localparam int LATS [4] = '{2, 1, 3, 7};
    localparam int DEPS [4] = '{4, 2, 2, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr = '0;
    logic        ceN = 1'b1, weN = 1'b1, oeN = 1'b1, ubN = 1'b1, lbN = 1'b1;
    logic        tbDrive = 1'b0;
    logic [15:0] tbData = '0;

    wire  [15:0] dq0, dq1, dq2, dq3;
    logic [15:0] dqObs [4];
    logic [3:0]  rdV;
    logic [15:0] rc [4];
    logic [15:0] wc [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dq0 = tbDrive ? tbData : 16'hzzzz;
    assign dq1 = tbDrive ? tbData : 16'hzzzz;
    assign dq2 = tbDrive ? tbData : 16'hzzzz;
    assign dq3 = tbDrive ? tbData : 16'hzzzz;
    assign dqObs[0] = dq0;
    assign dqObs[1] = dq1;
    assign dqObs[2] = dq2;
    assign dqObs[3] = dq3;

    for (genvar b = 0; b < 16; b++) begin : g_pull
        pullup (dq0[b]);
        pullup (dq1[b]);
        pullup (dq2[b]);
        pullup (dq3[b]);
    end

    sram_responder #(.MEM_DEPTH_LOG2(DEPS[0]), .READ_LAT(LATS[0])) u_dut0 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr), .SRAM_UB_N(ubN),
        .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN),
        .rdValid(rdV[0]), .readCount(rc[0]), .writeCount(wc[0]));
    sram_responder #(.MEM_DEPTH_LOG2(DEPS[1]), .READ_LAT(LATS[1])) u_dut1 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ubN),
        .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN),
        .rdValid(rdV[1]), .readCount(rc[1]), .writeCount(wc[1]));
    sram_responder #(.MEM_DEPTH_LOG2(DEPS[2]), .READ_LAT(LATS[2])) u_dut2 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr), .SRAM_UB_N(ubN),
        .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN),
        .rdValid(rdV[2]), .readCount(rc[2]), .writeCount(wc[2]));
    sram_responder #(.MEM_DEPTH_LOG2(DEPS[3]), .READ_LAT(LATS[3])) u_dut3 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ubN),
        .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN),
        .rdValid(rdV[3]), .readCount(rc[3]), .writeCount(wc[3]));

    // Reference model: a read becomes visible once it has been held on one
    // aliased address for READ_LAT-1 edges after the edge that first saw it.
    logic [15:0] mMem [4][32];
    bit          mActive [4];
    bit          mShown [4];
    int          mStart [4];
    int          mAddr [4];
    logic [15:0] mData [4];
    logic [15:0] mRc [4];
    logic [15:0] mWc [4];
    int          cyc = 0;

    function automatic int aliasIdx(int i);
        return int'(addr) % (1 << DEPS[i]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mActive[i] = 0;
            mShown[i]  = 0;
            mRc[i]     = 16'd0;
            mWc[i]     = 16'd0;
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = aliasIdx(i);
            if (rst) begin
                mActive[i] = 0;
                mShown[i]  = 0;
                mRc[i]     = 16'd0;
                mWc[i]     = 16'd0;
            end else if (!ceN && !weN) begin
                if (!ubN) mMem[i][idx][15:8] = tbData[15:8];
                if (!lbN) mMem[i][idx][7:0]  = tbData[7:0];
                mWc[i]     = mWc[i] + 16'd1;
                mActive[i] = 0;
                mShown[i]  = 0;
            end else if (!ceN && weN && !oeN) begin
                if (!mActive[i] || idx != mAddr[i]) begin
                    mActive[i] = 1;
                    mShown[i]  = 0;
                    mStart[i]  = cyc;
                    mAddr[i]   = idx;
                end
                if (!mShown[i] && (cyc - mStart[i]) >= LATS[i] - 1) begin
                    mShown[i] = 1;
                    mData[i]  = mMem[i][idx];
                    mRc[i]    = mRc[i] + 16'd1;
                end
            end else begin
                mActive[i] = 0;
                mShown[i]  = 0;
            end
        end
        cyc++;
    endtask

    function automatic logic [15:0] expDq(int i);
        logic [15:0] e;
        logic        en;
        en = mShown[i] && !ceN && !oeN && weN;
        e  = tbDrive ? tbData : 16'hFFFF;
        if (en && !ubN) e[15:8] = mData[i][15:8];
        if (en && !lbN) e[7:0]  = mData[i][7:0];
        return e;
    endfunction

    task automatic chk(string tag, int i, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, i, got, exp);
        end
    endtask

    task automatic checkAll(string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".dq"}, i, dqObs[i], expDq(i));
            chk({tag, ".rdValid"}, i, {15'd0, rdV[i]}, {15'd0, mShown[i]});
            chk({tag, ".readCount"}, i, rc[i], mRc[i]);
            chk({tag, ".writeCount"}, i, wc[i], mWc[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setIdle();
        ceN = 1'b1; weN = 1'b1; oeN = 1'b1; ubN = 1'b1; lbN = 1'b1; tbDrive = 1'b0;
    endtask

    task automatic setWrite(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        addr = a; tbData = d; tbDrive = 1'b1; ceN = 1'b0; weN = 1'b0; oeN = 1'b1; ubN = ub; lbN = lb;
    endtask

    task automatic setRead(input logic [17:0] a, input logic ub, input logic lb);
        addr = a; tbDrive = 1'b0; ceN = 1'b0; weN = 1'b1; oeN = 1'b0; ubN = ub; lbN = lb;
    endtask

    task automatic doWrite(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        setWrite(a, d, ub, lb);
        tick();
        checkAll("write");
    endtask

    initial begin
        logic [15:0] rcBase;
        modelReset();
        setIdle();

        // Reset state
        tick();
        tick();
        checkAll("reset");
        for (int i = 0; i < 4; i++) chk("resetDqZ", i, dqObs[i], 16'hFFFF);
        rst = 1'b0;

        // Basic write/read and latency sweep over the four latencies
        doWrite(18'h00010, 16'hA5C3, 1'b0, 1'b0);
        setRead(18'h00010, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin
            tick();
            checkAll("latSweep");
            for (int i = 0; i < 4; i++)
                chk("latData", i, dqObs[i], (j >= LATS[i] - 1) ? 16'hA5C3 : 16'hFFFF);
            if (j == 1) begin
                chk("firstReadCount", 0, rc[0], 16'd1);
                chk("firstWriteCount", 0, wc[0], 16'd1);
                chk("firstRdValid", 0, {15'd0, rdV[0]}, 16'd1);
            end
        end
        setIdle();
        tick();

        for (int a = 0; a < 32; a++) doWrite(18'(a), 16'($urandom), 1'b0, 1'b0);

        // Byte-lane masked write, then live lane masking on read
        doWrite(18'd5, 16'h1234, 1'b0, 1'b0);
        doWrite(18'd5, 16'hFFEE, 1'b1, 1'b0);
        setRead(18'd5, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin tick(); checkAll("laneRead"); end
        for (int i = 0; i < 4; i++) chk("laneData", i, dqObs[i], 16'h12EE);
        lbN = 1'b1;
        #1;
        checkAll("laneLive");
        for (int i = 0; i < 4; i++) chk("laneLowZ", i, dqObs[i], 16'h12FF);
        setIdle();
        tick();

        // Address change while waiting restarts latency, one count only
        doWrite(18'd6, 16'h6666, 1'b0, 1'b0);
        rcBase = mRc[2];
        setRead(18'd5, 1'b0, 1'b0);
        tick();
        checkAll("restartA");
        setRead(18'd6, 1'b0, 1'b0);
        tick();
        checkAll("restartB");
        tick();
        checkAll("restartC");
        chk("restartNotYet", 2, dq2, 16'hFFFF);
        tick();
        checkAll("restartD");
        chk("restartData", 2, dq2, 16'h6666);
        chk("restartCount", 2, rc[2], rcBase + 16'd1);
        for (int j = 0; j < 5; j++) begin tick(); checkAll("restartHold"); end
        setIdle();
        tick();

        // Write during DRIVE aborts the read and the new data lands
        setRead(18'd5, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin tick(); checkAll("preAbort"); end
        setWrite(18'd5, 16'h0F0F, 1'b0, 1'b0);
        #1;
        checkAll("abortLive");
        for (int i = 0; i < 4; i++) chk("abortBusOnlyTb", i, dqObs[i], 16'h0F0F);
        tick();
        checkAll("abortEdge");
        for (int i = 0; i < 4; i++) chk("abortRdValid", i, {15'd0, rdV[i]}, 16'd0);
        setIdle();
        tick();
        setRead(18'd5, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin tick(); checkAll("postAbort"); end
        for (int i = 0; i < 4; i++) chk("postAbortData", i, dqObs[i], 16'h0F0F);
        setIdle();
        tick();

        // Address aliasing on the 4-word instances
        doWrite(18'd3, 16'hC0DE, 1'b0, 1'b0);
        setRead(18'h00013, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin tick(); checkAll("alias"); end
        for (int i = 1; i < 4; i++) chk("aliasData", i, dqObs[i], 16'hC0DE);

        // Asynchronous reset between edges while driving
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll("asyncReset");
        for (int i = 0; i < 4; i++) chk("asyncResetDq", i, dqObs[i], 16'hFFFF);
        setIdle();
        #3;
        rst = 1'b0;
        tick();
        checkAll("postReset");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                setWrite(18'($urandom_range(0, 31)), 16'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 8) begin
                logic [17:0] a;
                a = ($urandom_range(0, 3) == 0 || weN == 1'b0 || ceN) ? 18'($urandom_range(0, 31)) : addr;
                setRead(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
                ubN = ~ubN;
                lbN = ~lbN;
            end else begin
                setIdle();
                ceN = 1'($urandom);
                oeN = ~ceN;
            end
            tick();
            checkAll("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
